// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS x 32-bit registers with independent write/read FSMs.
// Optional: define AXI_LITE_REGFILE_ID_REG_EN to make register 0 a read-only ID word.
module axi_lite_slave_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_LITE_REGFILE_ID_REG_EN
    localparam logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA5A5_0001;
`endif

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t wstate, wstate_next;
    rstate_t rstate, rstate_next;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_in_range, rd_in_range, wr_ok;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [1:0]            rd_resp;
    logic                  unused_addr_lsbs;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    // A beat arriving this cycle is used directly so B can follow one cycle after the later handshake.
    assign commit = (wstate == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_addr = aw_held ? awaddr_q : awaddr;
    assign wr_data = w_held ? wdata_q : wdata;
    assign wr_strb = w_held ? wstrb_q : wstrb;

    assign wr_idx      = wr_addr[2 +: IDX_W];
    assign rd_idx      = araddr[2 +: IDX_W];
    assign wr_in_range = (wr_addr[ADDR_WIDTH-1:2+IDX_W] == '0);
    assign rd_in_range = (araddr[ADDR_WIDTH-1:2+IDX_W] == '0);
    assign unused_addr_lsbs = ^{wr_addr[1:0], araddr[1:0]};

`ifdef AXI_LITE_REGFILE_ID_REG_EN
    assign wr_ok = wr_in_range && (wr_idx != '0);
`else
    assign wr_ok = wr_in_range;
`endif

    always_comb begin
        rd_word = regs[rd_idx];
        rd_resp = RESP_OKAY;
`ifdef AXI_LITE_REGFILE_ID_REG_EN
        if (rd_idx == '0) rd_word = ID_VALUE;
`endif
        if (!rd_in_range) begin
            rd_word = '0;
            rd_resp = RESP_SLVERR;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_next;
            rstate <= rstate_next;
        end
    end

    always_comb begin
        wstate_next = wstate;
        case (wstate)
            W_IDLE:  if (commit)           wstate_next = W_RESP;
            W_RESP:  if (bvalid && bready) wstate_next = W_IDLE;
            default:                       wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_next = rstate;
        case (rstate)
            R_IDLE:  if (ar_hs)            rstate_next = R_DATA;
            R_DATA:  if (rvalid && rready) rstate_next = R_IDLE;
            default:                       rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            awready  <= 1'b0;
            wready   <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else if (wstate == W_IDLE) begin
            if (commit) begin
                awready <= 1'b0;
                wready  <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    awaddr_q <= awaddr;
                    awready  <= 1'b0;
                end else if (!aw_held) begin
                    awready <= 1'b1;
                end
                if (w_hs) begin
                    w_held  <= 1'b1;
                    wdata_q <= wdata;
                    wstrb_q <= wstrb;
                    wready  <= 1'b0;
                end else if (!w_held) begin
                    wready <= 1'b1;
                end
            end
        end else if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Capture uses pre-edge register contents, so a same-edge write is not visible to this read.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else if (rstate == R_IDLE) begin
            if (ar_hs) begin
                arready <= 1'b0;
                rvalid  <= 1'b1;
                rdata   <= rd_word;
                rresp   <= rd_resp;
            end else begin
                arready <= 1'b1;
            end
        end else if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
        end
    end
endmodule

// File: doc/axi_lite_slave_regfile.md
Name: axi_lite_slave_regfile

Overview:
- AXI4-Lite responder: a bank of NUM_REGS 32-bit registers.
- Sits at the slave end of the shared AXI interface and answers master write and read transactions.
- Write path (AW/W/B) and read path (AR/R) are independent FSMs sharing one register array.
- Gives the bench a scoreboardable endpoint with deterministic latency and error responses.

Parameters:
ADDR_WIDTH, 32, byte-address width of awaddr/araddr
DATA_WIDTH, 32, data width; fixed at 32 for this block
NUM_REGS, 16, number of word registers; power of two, >= 2

Ports:
aclk  in  1  clock, rising edge
areset_n  in  1  asynchronous active-low reset
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response (00 OKAY, 10 SLVERR)
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read response valid
rready  in  1  read response ready

Behaviour:
- Reset (areset_n low, async): all registers, awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata = 0. Both FSMs go to IDLE. A reset mid-transaction drops it; no response is issued.
- All outputs are registered. Readies rise on the first aclk edge after reset release.
- Decode: idx = addr[2 +: log2(NUM_REGS)]. In range iff (addr >> 2) < NUM_REGS. addr[1:0] is ignored.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, AW and W are accepted independently, in either order or the same cycle.
  - awready drops the cycle after the AW handshake; wready drops the cycle after the W handshake. Each captured beat is held.
  - Once both are held: perform the write in that edge, set bvalid = 1 next cycle, go to W_RESP.
  - In range: byte lanes with wstrb = 1 are updated, bresp = 00.
  - Out of range: no update, bresp = 10.
  - W_RESP: hold bvalid and bresp until bready. On the handshake, bvalid = 0, awready = wready = 1, return to W_IDLE.
  - wstrb = 0 gives bresp = 00 with no change.
- Read FSM states: R_IDLE, R_DATA.
  - In R_IDLE, arready = 1. On the handshake, arready = 0. Next cycle rvalid = 1, rdata = reg[idx] (or 0 with rresp = 10 if out of range). Go to R_DATA.
  - Hold rdata, rresp and rvalid until rready. On the handshake, rvalid = 0, arready = 1.
- Latency: B follows 1 cycle after the later of AW/W. R follows 1 cycle after AR. Peak rate is 1 transaction per 2 cycles per path.
- Same-edge write commit and read capture to the same register: read returns the pre-write value.
- A stalled bready never blocks reads, and vice versa.

Optional Feature:
AXI_LITE_REGFILE_ID_REG_EN
- Defined:
  - Register 0 is a read-only ID that reads 32'hA5A5_0001.
  - Writes to idx 0 do not modify it and return bresp = 10.
  - Reads of idx 0 return the ID with rresp = 00.
- Undefined: register 0 is an ordinary read/write register.

Test Plan:
- After reset release: AW 0x08 and W 0xDEADBEEF with wstrb 0xF in the same cycle -> bvalid one cycle later, bresp 00. Then AR 0x08 -> rvalid next cycle, rdata 0xDEADBEEF, rresp 00.
- W (0x12345678) sent 3 cycles before AW 0x04 -> wready low while waiting. bvalid 1 cycle after AW. Read 0x04 returns 0x12345678.
- Write 0x000000FF to 0x0C with wstrb 0x1 onto prior value 0xAABBCCDD -> readback 0xAABBCCFF.
- AW 0x40 (NUM_REGS 16) -> bresp 10, no register changes. AR 0x40 -> rdata 0, rresp 10.
- Hold bready = 0 for 5 cycles -> bvalid and bresp stable. Concurrent AR 0x08 completes during the stall.
- Assert areset_n = 0 while bvalid = 1 -> bvalid and rvalid = 0 immediately, registers read 0 afterward. With the macro defined: read 0x00 -> 0xA5A5_0001; write 0x00 -> bresp 10.
